// File: rtl/decode_stage.sv
// RV32I decode stage: IF/ID register, field/immediate decode, illegal-opcode
// detection and a one-bubble load-use interlock toward the fetch stage.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module decode_stage #(
  parameter int WORD_SIZE = `WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic [WORD_SIZE-1:0] pc_in,
  input  logic [WORD_SIZE-1:0] instruction_in,
  input  logic                 exception_in,
  input  logic                 flush,
  input  logic                 stall_in,
  output logic                 stall_out,
  output logic                 valid_out,
  output logic [WORD_SIZE-1:0] pc_out,
  output logic                 exception_out,
  output logic [4:0]           rs1,
  output logic [4:0]           rs2,
  output logic [4:0]           rd,
  output logic [2:0]           funct3,
  output logic [6:0]           funct7,
  output logic [WORD_SIZE-1:0] imm,
  output logic                 is_load,
  output logic                 is_store,
  output logic                 is_branch,
  output logic                 is_jump,
  output logic                 uses_rs1,
  output logic                 uses_rs2
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  logic                 r_valid, r_exc, r_ld_valid;
  logic [WORD_SIZE-1:0] r_pc, r_instr;
  logic [4:0]           r_ld_rd;
  logic [31:0]          w_ins, w_imm32;
  logic                 w_legal, w_hazard, w_stall, w_issue;

  assign w_ins  = r_instr[31:0];
  assign rs1    = w_ins[19:15];
  assign rs2    = w_ins[24:20];
  assign rd     = w_ins[11:7];
  assign funct3 = w_ins[14:12];
  assign funct7 = w_ins[31:25];
  assign pc_out = r_pc;
  assign imm    = WORD_SIZE'($signed(w_imm32));

  always_comb begin
    w_legal   = 1'b1;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    uses_rs1  = 1'b1;
    uses_rs2  = 1'b0;
    w_imm32   = {{20{w_ins[31]}}, w_ins[31:20]};
    case (w_ins[6:0])
      OP_LUI, OP_AUIPC: begin
        uses_rs1 = 1'b0;
        w_imm32  = {w_ins[31:12], 12'b0};
      end
      OP_JAL: begin
        uses_rs1 = 1'b0;
        is_jump  = 1'b1;
        w_imm32  = {{12{w_ins[31]}}, w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};
      end
      OP_JALR: is_jump = 1'b1;
      OP_BRANCH: begin
        is_branch = 1'b1;
        uses_rs2  = 1'b1;
        w_imm32   = {{20{w_ins[31]}}, w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
      end
      OP_LOAD: is_load = 1'b1;
      OP_STORE: begin
        is_store = 1'b1;
        uses_rs2 = 1'b1;
        w_imm32  = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
      end
      OP_IMM: ;
      OP_OP: uses_rs2 = 1'b1;
      default: begin
        w_legal  = 1'b0;
        uses_rs1 = 1'b0;
      end
    endcase
  end

  // Only an issued load with a non-zero rd can block the instruction behind it.
  assign w_hazard = r_valid && !r_exc && r_ld_valid && (r_ld_rd != 5'd0) &&
                    ((uses_rs1 && rs1 == r_ld_rd) || (uses_rs2 && rs2 == r_ld_rd));
  assign w_stall       = stall_in || w_hazard;
  assign w_issue       = r_valid && !w_hazard;
  assign valid_out     = w_issue;
  assign stall_out     = rst && w_stall;
  assign exception_out = r_valid && (r_exc || !w_legal);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid    <= 1'b0;
      r_exc      <= 1'b0;
      r_pc       <= '0;
      r_instr    <= '0;
      r_ld_valid <= 1'b0;
      r_ld_rd    <= 5'd0;
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
      end else if (!w_stall) begin
        r_valid <= valid_in;
        r_pc    <= pc_in;
        r_instr <= instruction_in;
        r_exc   <= exception_in;
      end
      // Tracker remembers only the instruction that actually left this stage.
      if (flush) begin
        r_ld_valid <= 1'b0;
      end else if (!stall_in) begin
        if (w_issue) begin
          r_ld_valid <= is_load;
          r_ld_rd    <= rd;
        end else begin
          r_ld_valid <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// Random + directed bench for decode_stage against a behavioural model of the
// held instruction and the last issued load.
module tb_decode_stage;
  logic        clk = 1'b0, rst = 1'b0;
  logic        valid_in = 1'b0, exception_in = 1'b0, flush = 1'b0, stall_in = 1'b0;
  logic [31:0] pc_in = '0, instruction_in = '0;
  logic        stall_out, valid_out, exception_out;
  logic [31:0] pc_out, imm;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        is_load, is_store, is_branch, is_jump, uses_rs1, uses_rs2;

  decode_stage #(.WORD_SIZE(32)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .pc_in(pc_in),
    .instruction_in(instruction_in), .exception_in(exception_in),
    .flush(flush), .stall_in(stall_in), .stall_out(stall_out),
    .valid_out(valid_out), .pc_out(pc_out), .exception_out(exception_out),
    .rs1(rs1), .rs2(rs2), .rd(rd), .funct3(funct3), .funct7(funct7), .imm(imm),
    .is_load(is_load), .is_store(is_store), .is_branch(is_branch),
    .is_jump(is_jump), .uses_rs1(uses_rs1), .uses_rs2(uses_rs2)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  // model: held instruction slot and last issued load
  bit          m_v, m_e, m_ldv;
  logic [31:0] m_pc, m_ins;
  logic [4:0]  m_ldrd;
  bit          e_stall, e_vo;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit legal(logic [6:0] op);
    return op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
  endfunction

  // immediates as signed integer arithmetic on the encoded bit groups
  function automatic logic [31:0] ref_imm(logic [31:0] i);
    int v;
    case (i[6:0])
      7'h37, 7'h17: v = int'(i[31:12]) * 4096;
      7'h23: begin v = int'(i[31:25]) * 32 + int'(i[11:7]); if (i[31]) v -= 4096; end
      7'h63: begin
        v = int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
        if (i[31]) v -= 4096;
      end
      7'h6F: begin
        v = int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
        if (i[31]) v -= 1048576;
      end
      default: begin v = int'(i[31:20]); if (i[31]) v -= 4096; end
    endcase
    return 32'(v);
  endfunction

  task automatic model_clear();
    m_v = 0; m_e = 0; m_ldv = 0; m_pc = '0; m_ins = '0; m_ldrd = '0;
  endtask

  // one clock: check at negedge, advance the model at posedge, return at posedge+1
  task automatic cyc();
    bit u1, u2, hz, n_v, n_e, n_ldv;
    logic [31:0] n_pc, n_ins;
    logic [4:0] n_ldrd;
    logic [6:0] op;
    @(negedge clk);
    if (!rst) model_clear();
    op = m_ins[6:0];
    u1 = legal(op) && !(op inside {7'h37, 7'h17, 7'h6F});
    u2 = op inside {7'h63, 7'h23, 7'h33};
    hz = m_v && !m_e && m_ldv && m_ldrd != 0 &&
         ((u1 && m_ins[19:15] == m_ldrd) || (u2 && m_ins[24:20] == m_ldrd));
    e_vo = m_v && !hz;
    e_stall = rst && (stall_in || hz);
    chk("valid_out", valid_out, e_vo);
    chk("stall_out", stall_out, e_stall);
    chk("exc_out", exception_out, m_v && (m_e || !legal(op)));
    if (e_vo) begin
      chk("pc_out", pc_out, m_pc);
      chk("fields", {rs1, rs2, rd, funct3, funct7},
          {m_ins[19:15], m_ins[24:20], m_ins[11:7], m_ins[14:12], m_ins[31:25]});
      chk("imm", imm, ref_imm(m_ins));
      chk("flags", {is_load, is_store, is_branch, is_jump, uses_rs1, uses_rs2},
          {op == 7'h03, op == 7'h23, op == 7'h63, op == 7'h6F || op == 7'h67, u1, u2});
    end
    {n_v, n_e, n_pc, n_ins, n_ldv, n_ldrd} = {m_v, m_e, m_pc, m_ins, m_ldv, m_ldrd};
    if (flush) n_v = 0;
    else if (!(stall_in || hz)) {n_v, n_e, n_pc, n_ins} = {valid_in, exception_in, pc_in, instruction_in};
    if (flush) n_ldv = 0;
    else if (!stall_in) begin
      n_ldv = e_vo && op == 7'h03;
      if (e_vo) n_ldrd = m_ins[11:7];
    end
    @(posedge clk);
    {m_v, m_e, m_pc, m_ins, m_ldv, m_ldrd} = {n_v, n_e, n_pc, n_ins, n_ldv, n_ldrd};
    if (!rst) model_clear();
    #1;
  endtask

  // present an instruction until the decode stage accepts it
  task automatic fetch(logic [31:0] pc, logic [31:0] ins, bit exc);
    int n = 0;
    valid_in = 1; pc_in = pc; instruction_in = ins; exception_in = exc;
    do begin cyc(); n++; end while (e_stall && n < 10);
    if (e_stall) chk("fetch_timeout", 1, 0);
    valid_in = 0;
  endtask

  initial begin
    logic [6:0] pool [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    logic [31:0] r;
    model_clear();
    // reset with stall_in and a valid fetch pending
    stall_in = 1; valid_in = 1; instruction_in = 32'h00500093;
    #12;
    chk("rst_valid", valid_out, 0);
    chk("rst_stall", stall_out, 0);
    chk("rst_exc", exception_out, 0);
    cyc(); cyc();
    rst = 1; stall_in = 0; valid_in = 0;

    fetch(32'h0, 32'h00500093, 0);           // addi x1,x0,5
    chk("addi_valid", valid_out, 1);
    chk("addi_rd", rd, 1);
    chk("addi_rs1", rs1, 0);
    chk("addi_imm", imm, 5);
    chk("addi_urs2", uses_rs2, 0);

    fetch(32'h4, 32'h0000A103, 0);           // lw x2,0(x1)
    fetch(32'h8, 32'h002101B3, 0);           // add x3,x2,x2
    chk("lu_bubble_valid", valid_out, 0);
    chk("lu_bubble_stall", stall_out, 1);
    cyc();
    chk("lu_issue_valid", valid_out, 1);
    chk("lu_issue_rd", rd, 3);

    fetch(32'hC, 32'h0000A003, 0);           // lw x0,0(x1)
    fetch(32'h10, 32'h000001B3, 0);          // add x3,x0,x0
    chk("x0_nobubble_valid", valid_out, 1);
    chk("x0_nobubble_stall", stall_out, 0);

    fetch(32'h40, 32'h00500093, 0);
    stall_in = 1; valid_in = 1; pc_in = 32'h44; instruction_in = 32'h00100113;
    repeat (3) begin
      cyc();
      chk("stall_pc", pc_out, 32'h40);
      chk("stall_out_held", stall_out, 1);
    end
    stall_in = 0; valid_in = 0;
    cyc();
    chk("no_dup_issue", valid_out, 0);

    fetch(32'h50, 32'h0000A283, 0);          // lw x5
    fetch(32'h54, 32'h00528333, 0);          // add x6,x5,x5 (lw issues here)
    flush = 1; stall_in = 1;
    cyc();
    chk("flush_valid", valid_out, 0);
    flush = 0; stall_in = 0;
    fetch(32'h80, 32'h00528333, 0);
    chk("flush_ld_cleared", stall_out, 0);

    fetch(32'h90, 32'hFFFFFFFF, 0);
    chk("illegal_exc", exception_out, 1);
    fetch(32'h94, 32'h0000A283, 0);
    fetch(32'h98, 32'h00528333, 1);
    chk("excin_exc", exception_out, 1);
    chk("excin_nobubble", stall_out, 0);

    fetch(32'hA0, 32'hFE208EE3, 0);          // beq x1,x2,-4
    chk("beq_imm", imm, 32'hFFFFFFFC);
    chk("beq_branch", is_branch, 1);
    chk("beq_urs2", uses_rs2, 1);

    // reset in the middle of a stall drops the held instruction
    fetch(32'hB0, 32'h00500093, 0);
    stall_in = 1;
    cyc();
    #2 rst = 0;
    #1;
    chk("midrst_valid", valid_out, 0);
    chk("midrst_stall", stall_out, 0);
    cyc();
    rst = 1; stall_in = 0;
    cyc();
    chk("midrst_noissue", valid_out, 0);

    for (int k = 0; k < 500; k++) begin
      if (!e_stall) begin
        r = $urandom;
        r[6:0]   = ($urandom_range(0, 15) == 0) ? 7'h7F : pool[$urandom_range(0, 8)];
        r[11:7]  = 5'($urandom_range(0, 3));
        r[19:15] = 5'($urandom_range(0, 3));
        r[24:20] = 5'($urandom_range(0, 3));
        instruction_in = r;
        pc_in = 32'(k * 4);
        valid_in = $urandom_range(0, 3) != 0;
        exception_in = $urandom_range(0, 15) == 0;
      end
      flush = $urandom_range(0, 9) == 0;
      stall_in = $urandom_range(0, 3) == 0;
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
